// File: rtl/output_uart_tx.sv
// Output-port UART: buffers 16-bit words and sends each as two 8N1 frames (high byte first).
// Latency: tx start bit begins 2 edges after the write strobe; strobes into a full FIFO are dropped.

module output_uart_tx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_vld_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  rd_dat_o,
  output logic [AW:0]   count_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign wr_en    = wr_vld_i && !full_o;
  assign rd_en    = pop_i && (count_q != '0);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

module output_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        data_for_output,
  input  logic               output_update,
  output logic               tx,
  output logic               busy,
  output logic               fifo_full,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    bit_nx;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q;
  logic          pop;
  logic          baud_last;
  logic [15:0]   head_word;

  output_uart_tx_fifo #(
    .W     (16),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_vld_i (output_update),
    .wr_dat_i (data_for_output),
    .pop_i    (pop),
    .rd_dat_o (head_word),
    .count_o  (fifo_count),
    .full_o   (fifo_full)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign bit_nx    = bit_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BW'(1);
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (fifo_count != '0) state_d = LOAD;
      end
      LOAD: begin
        word_d     = head_word;
        byte_sel_d = 1'b0;
        pop        = 1'b1;
        state_d    = START;
        baud_d     = '0;
        tx_d       = 1'b0;
      end
      START: begin
        // Shift register is loaded during the start bit; CLKS_PER_BIT >= 2 guarantees it is ready for DATA.
        if (baud_q == '0) shift_d = byte_sel_q ? word_q[7:0] : word_q[15:8];
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = shift_q[bit_nx];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      if (output_update && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_output_uart_tx.sv
// Directed bench for output_uart_tx with CLKS_PER_BIT=4 and a line-side UART receiver.
module tb_output_uart_tx;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        output_update = 1'b0;
  logic [15:0] data_for_output = 16'h0;
  logic        tx, busy, fifo_full, overflow;
  logic [2:0]  fifo_count;

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [7:0]  rx_q[$];
  int          t_q[$];
  logic [15:0] exp_q[$];

  output_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .FIFO_AW      (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .data_for_output (data_for_output),
    .output_update   (output_update),
    .tx              (tx),
    .busy            (busy),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .fifo_count      (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line receiver: samples mid-bit, one sample per clock at the falling edge.
  initial begin
    int ph;
    logic act;
    logic [7:0] b;
    act = 1'b0;
    ph = 0;
    b = 8'h0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          ph = 0;
          b = 8'h0;
          t_q.push_back(cyc);
        end
      end else begin
        ph++;
        if (ph == 2) chk("start_bit", {31'h0, tx}, 32'h0);
        if (ph >= 6 && ph <= 34 && ((ph - 2) % 4) == 0) b[(ph - 6) / 4] = tx;
        if (ph == 38) begin
          chk("stop_bit", {31'h0, tx}, 32'h1);
          rx_q.push_back(b);
          act = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [15:0] w);
    @(posedge clock);
    #1;
    data_for_output = w;
    output_update = 1'b1;
    @(posedge clock);
    #1;
    output_update = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clock);
    chk("idle_wait", {31'h0, busy}, 32'h0);
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (rx_q.size() >= 2) begin
      got[31:16] = 16'h0;
      got[15:8] = rx_q.pop_front();
      got[7:0] = rx_q.pop_front();
    end
    chk(tag, got, {16'h0, w});
  endtask

  initial begin
    bit [0:19]   seq;
    logic [79:0] obs;
    logic        b79;
    int          k;
    int          lows;
    logic [15:0] w;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_full", {31'h0, fifo_full}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_count", {29'h0, fifo_count}, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    // Single word 0xA55A
    seq = 20'b01010010110010110101;
    strobe(16'hA55A);
    k = 0;
    while (k < 10) begin
      @(negedge clock);
      if (tx === 1'b0) break;
      k++;
    end
    chk("tx_fall_latency", k, 2);
    b79 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clock);
      obs[i] = tx;
      if (i == 79) b79 = busy;
    end
    for (int j = 0; j < 20; j++)
      chk($sformatf("a55a_bit%0d", j), {28'h0, obs[4*j +: 4]}, {28'h0, {4{seq[j]}}});
    chk("busy_in_last_stop", {31'h0, b79}, 32'h1);
    @(negedge clock);
    chk("busy_after_word", {31'h0, busy}, 32'h0);
    chk("tx_after_word", {31'h0, tx}, 32'h1);
    chk("count_after_word", {29'h0, fifo_count}, 32'h0);
    chk_word("rx_a55a", 16'hA55A);

    // Burst of 6 strobes on consecutive edges
    rx_q.delete();
    @(posedge clock);
    #1 output_update = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      data_for_output = 16'(i);
      @(posedge clock);
      #1;
      if (i == 3) chk("wr_pop_same_edge_count", {29'h0, fifo_count}, 32'h2);
      if (i == 4) chk("full_before_5th", {31'h0, fifo_full}, 32'h0);
      if (i == 5) begin
        chk("full_on_5th", {31'h0, fifo_full}, 32'h1);
        chk("count_on_5th", {29'h0, fifo_count}, 32'h4);
        chk("ovf_before_6th", {31'h0, overflow}, 32'h0);
      end
      if (i == 6) begin
        chk("ovf_on_6th", {31'h0, overflow}, 32'h1);
        chk("count_after_drop", {29'h0, fifo_count}, 32'h4);
      end
    end
    output_update = 1'b0;
    wait_idle(3000);
    chk("burst_rx_bytes", rx_q.size(), 10);
    for (int i = 1; i <= 5; i++) chk_word($sformatf("burst_word%0d", i), 16'(i));
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Reset during DATA bit 3 of high byte (0x12: bit3 = 0)
    rx_q.delete();
    strobe(16'h1234);
    strobe(16'h5678);
    k = 0;
    while (k < 20) begin
      @(negedge clock);
      if (tx === 1'b0) break;
      k++;
    end
    chk("midrst_start_seen", {31'h0, tx}, 32'h0);
    repeat (17) @(negedge clock);
    chk("midrst_bit3_low", {31'h0, tx}, 32'h0);
    chk("midrst_count_pre", {29'h0, fifo_count}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx", {31'h0, tx}, 32'h1);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_full", {31'h0, fifo_full}, 32'h0);
    chk("midrst_ovf", {31'h0, overflow}, 32'h0);
    chk("midrst_count", {29'h0, fifo_count}, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("no_residual_frame", lows, 0);
    chk("no_residual_bytes", rx_q.size(), 0);
    chk("idle_after_rst", {31'h0, busy}, 32'h0);

    // Wrap-around: 10 words, one strobe every 100 cycles
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      w = 16'(16'h3C5A + i * 16'h1111);
      exp_q.push_back(w);
      strobe(w);
      repeat (98) @(posedge clock);
    end
    wait_idle(500);
    chk("wrap_rx_bytes", rx_q.size(), 20);
    for (int i = 0; i < 10; i++) chk_word($sformatf("wrap_word%0d", i), exp_q[i]);
    chk("wrap_ovf", {31'h0, overflow}, 32'h0);
    chk("wrap_count", {29'h0, fifo_count}, 32'h0);

    // Gap check: two queued words
    rx_q.delete();
    t_q.delete();
    @(posedge clock);
    #1;
    data_for_output = 16'hF00F;
    output_update = 1'b1;
    @(posedge clock);
    #1 data_for_output = 16'h0FF0;
    @(posedge clock);
    #1 output_update = 1'b0;
    wait_idle(1000);
    chk("gap_frames", t_q.size(), 4);
    if (t_q.size() >= 4) begin
      chk("gap_hi_lo_w1", t_q[1] - t_q[0] - 10 * CPB, 0);
      chk("gap_between_words", t_q[2] - t_q[1] - 10 * CPB, 2);
      chk("gap_hi_lo_w2", t_q[3] - t_q[2] - 10 * CPB, 0);
    end
    chk_word("gap_word1", 16'hF00F);
    chk_word("gap_word2", 16'h0FF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/output_uart_tx.md
Name: output_uart_tx

Overview:
- Serial transmitter for the processor's output port.
- Captures each 16-bit word the core presents on data_for_output when the core pulses its output-update strobe.
- Buffers captured words in a small FIFO and sends each word as two UART 8N1 frames on a single tx line: high byte first, then low byte.
- Sits at the top level beside pipeline_processor. Its inputs connect to data_for_output and to the EX-stage output-update strobe, which is brought out of the core.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, number of word entries; must be a power of two.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clock  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- data_for_output  in  16  word from the processor output register.
- output_update  in  1  one-cycle write strobe; data_for_output is valid in the same cycle.
- tx  out  1  serial line; idle high.
- busy  out  1  high when state != IDLE or fifo_count != 0.
- fifo_full  out  1  high when fifo_count == FIFO_DEPTH.
- overflow  out  1  sticky; set when a strobe arrives while the FIFO is full.
- fifo_count  out  FIFO_AW+1  number of words held in the FIFO.

Behaviour:
- Reset (reset low): applies asynchronously and immediately.
  - tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0.
  - FIFO pointers=0, state=IDLE, all counters=0.
  - Reset mid-frame aborts the frame and forces tx high at once. Buffered words are discarded.
- FIFO:
  - Write on a rising edge with output_update=1 and fifo_full=0.
  - fifo_full is evaluated on the registered count before that edge. A strobe while full is dropped and sets overflow, even if a pop happens on the same edge.
  - Pop happens on the edge that leaves LOAD.
  - Simultaneous write and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_count != 0, go to LOAD on the next edge.
- LOAD (1 cycle):
  - Latch the head word into word_reg, set byte_sel=0, pop the FIFO.
  - Go to START.
- START:
  - Register the shift register with word_reg[15:8] when byte_sel=0, or word_reg[7:0] when byte_sel=1.
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, LSB first.
  - Each bit is held CLKS_PER_BIT cycles; bit counter 0..7.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then, if byte_sel=0: set byte_sel=1 and go to START, with no extra idle gap.
  - Otherwise go to IDLE.
- tx is driven from a register (glitch-free).
- Frame = 10*CLKS_PER_BIT cycles; word = 20*CLKS_PER_BIT cycles.
- Latency: strobe sampled at edge E leads to IDLE->LOAD at E+1 and LOAD->START at E+2. tx is low during the cycle after E+2.
- Back-to-back words: after the low byte's STOP, IDLE lasts one cycle when the FIFO is non-empty, then LOAD. The inter-word gap is 2 cycles of tx=1.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state change, and has no drift across bits.
- Words are transmitted in strobe order. A word is never partially sent except when reset aborts it.
- overflow clears only on reset.

Test Plan:
- Single word:
  - Stimulus: CLKS_PER_BIT=4; strobe 0xA55A once.
  - Required: tx falls 2 cycles after the write edge.
  - Bit sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1.
  - Exactly 80 cycles total; busy falls after the final stop bit; fifo_count returns to 0.
- Burst overflow:
  - Stimulus: 6 strobes on consecutive edges from idle, words 0x0001..0x0006.
  - Required: 0x0001..0x0005 accepted and sent in order; 0x0006 dropped; overflow=1 and stays 1.
  - fifo_full asserted on the edge the 5th word is written.
- Write and pop in the same cycle: strobe on the edge leaving LOAD with fifo_count=2 -> fifo_count stays 2 and no word is lost.
- Reset mid-frame:
  - Stimulus: assert reset (low) during DATA bit 3 of the high byte, then release.
  - Required: tx=1 immediately without waiting for an edge; all outputs at reset values; no residual frame after release.
- Wrap-around: stream 10 words with one strobe every 100 cycles (CLKS_PER_BIT=4) -> pointers wrap; all 10 words received correctly by a bench UART model; overflow stays 0.
- Gap check: two queued words -> exactly 2 idle-high cycles between word 1's low-byte stop bit and word 2's start bit; 0 cycles between the high and low bytes of one word.
